// File: rtl/mdw_pkg.sv
// Shared types and helpers for the missing-duplicated-word finder and its
// table generator: word/slot types, FSM states, LFSR and slot stepping.
package mdw_pkg;

    localparam int W = 5;
    localparam int N = 17;
    localparam int STRIDE = 3;
    localparam logic [W-1:0] TAPS = 5'b10100;

    localparam int K = (N - 1) / 2;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(K + 1);

    typedef logic [W-1:0] w_t;
    typedef logic [IW-1:0] id_t;
    typedef logic [CW-1:0] cnt_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        UNIQ,
        DRAIN,
        DONE
    } gen_st_t;

    // Fibonacci-style shift left, feedback is the parity of the tapped bits
    function automatic w_t lfsr_next(w_t v, w_t taps);
        return {v[W-2:0], ^(v & taps)};
    endfunction

    // Step a slot by STRIDE modulo N using one guard bit
    function automatic id_t slot_next(id_t s);
        logic [IW:0] t;
        t = {1'b0, s} + (IW+1)'(STRIDE);
        if (t >= (IW+1)'(N))
            t = t - (IW+1)'(N);
        return t[IW-1:0];
    endfunction

endpackage

// File: rtl/mdw_lifo.sv
// Small push/pop stack used to replay the second copy of each pair value
// in reverse order of the first copies.
module mdw_lifo
    import mdw_pkg::*;
#(
    parameter int DEPTH = K,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_m1;

    assign ptr_m1 = ptr - 1'b1;
    assign top    = mem[ptr_m1[AW-1:0]];
    assign empty  = (ptr == '0);
    assign full   = (ptr == PW'(DEPTH));

    // Storage write on push; contents need no reset
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr[AW-1:0]] <= din;
    end

    // Stack pointer: count of valid entries
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (push && !pop)
            ptr <= ptr + 1'b1;
        else if (pop && !push)
            ptr <= ptr - 1'b1;
    end

    // The generator never overfills or underflows the stack
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end

endmodule

// File: rtl/missing_duplicated_word_gen.sv
// Table writer for the missing-duplicated-word finder: K LFSR pair values
// written twice (second copies via LIFO) plus one unique word, strided slots.
module missing_duplicated_word_gen
    import mdw_pkg::*;
#(
    parameter int W = mdw_pkg::W,
    parameter int N = mdw_pkg::N,
    parameter int STRIDE = mdw_pkg::STRIDE,
    parameter logic [W-1:0] TAPS = mdw_pkg::TAPS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_start,
    input  logic [W-1:0]         gen_seed,
    input  logic [W-1:0]         gen_unique,
    output logic                 gen_busy_r,
    output logic                 gen_done_r,
    output logic                 state_upt,
    output logic [$clog2(N)-1:0] state_id,
    output logic [W-1:0]         state_dat,
    input  logic                 state_rdy
);

    // Types and helpers come from the shared package; overrides must agree
    localparam bit PARAM_OK = (W == mdw_pkg::W) && (N == mdw_pkg::N)
                           && (STRIDE == mdw_pkg::STRIDE)
                           && (TAPS == mdw_pkg::TAPS);

    gen_st_t st;
    w_t      lfsr;
    w_t      uniq_r;
    id_t     slot;
    cnt_t    cnt;

    logic skip;
    logic acc;
    logic push;
    logic pop;
    w_t   lifo_top;
    logic lifo_empty;
    logic lifo_full;

    // Output word selection and handshake qualifiers
    always_comb begin
        skip      = (st == FILL) && (lfsr == uniq_r);
        state_upt = ((st == FILL) && !skip) || (st == UNIQ) || (st == DRAIN);
        state_id  = slot;
        state_dat = lfsr;
        unique case (1'b1)
            (st == UNIQ):  state_dat = uniq_r;
            (st == DRAIN): state_dat = lifo_top;
            default:       state_dat = lfsr;
        endcase
        acc  = state_upt && state_rdy;
        push = (st == FILL) && acc;
        pop  = (st == DRAIN) && acc;
    end

    // Generator sequencer with registered busy/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            lfsr       <= w_t'(1);
            uniq_r     <= '0;
            slot       <= '0;
            cnt        <= '0;
            gen_busy_r <= 1'b0;
            gen_done_r <= 1'b0;
        end else begin
            gen_done_r <= 1'b0;
            case (st)
                IDLE: begin
                    if (gen_start) begin
                        uniq_r     <= gen_unique;
                        lfsr       <= (gen_seed == '0) ? w_t'(1) : gen_seed;
                        slot       <= '0;
                        cnt        <= '0;
                        gen_busy_r <= 1'b1;
                        st         <= FILL;
                    end
                end
                FILL: begin
                    if (skip) begin
                        lfsr <= lfsr_next(lfsr, TAPS);
                    end else if (acc) begin
                        lfsr <= lfsr_next(lfsr, TAPS);
                        slot <= slot_next(slot);
                        cnt  <= cnt + 1'b1;
                        if (cnt == cnt_t'(K - 1))
                            st <= UNIQ;
                    end
                end
                UNIQ: begin
                    if (acc) begin
                        slot <= slot_next(slot);
                        st   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (acc) begin
                        slot <= slot_next(slot);
                        cnt  <= cnt - 1'b1;
                        if (cnt == cnt_t'(1)) begin
                            gen_busy_r <= 1'b0;
                            gen_done_r <= 1'b1;
                            st         <= DONE;
                        end
                    end
                end
                DONE: begin
                    st <= IDLE;
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

    mdw_lifo #(
        .DEPTH(K),
        .W    (W)
    ) u_lifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .din  (lfsr),
        .top  (lifo_top),
        .empty(lifo_empty),
        .full (lifo_full)
    );

    // Parameter agreement and stack occupancy sanity
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (PARAM_OK);
            assert (!((st == DRAIN) && lifo_empty));
            assert (!((st == UNIQ) && !lifo_full));
        end
    end

endmodule

// File: tb/tb_missing_duplicated_word_gen.sv
// Randomized self-checking bench for missing_duplicated_word_gen against a
// list-based model of the expected write sequence.
module tb_missing_duplicated_word_gen;

    localparam int W = 5;
    localparam int N = 17;
    localparam int STRIDE = 3;
    localparam int K = (N - 1) / 2;
    localparam logic [W-1:0] TAPS = 5'b10100;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gen_start = 1'b0;
    logic [W-1:0]  gen_seed = '0;
    logic [W-1:0]  gen_unique = '0;
    logic          gen_busy_r;
    logic          gen_done_r;
    logic          state_upt;
    logic [IW-1:0] state_id;
    logic [W-1:0]  state_dat;
    logic          state_rdy = 1'b1;

    missing_duplicated_word_gen dut (
        .clk       (clk),
        .rst       (rst),
        .gen_start (gen_start),
        .gen_seed  (gen_seed),
        .gen_unique(gen_unique),
        .gen_busy_r(gen_busy_r),
        .gen_done_r(gen_done_r),
        .state_upt (state_upt),
        .state_id  (state_id),
        .state_dat (state_dat),
        .state_rdy (state_rdy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int exp_id[$];
    int exp_dat[$];
    int m_skips;

    bit mon_on = 0;
    int cyc;
    int last_acc;
    int done_cyc;
    bit stall_prev;
    int stall_id;
    int stall_dat;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected writes: pairs in LFSR order, the unique word, pairs reversed
    task automatic build(input logic [W-1:0] seed, input logic [W-1:0] uq);
        logic [W-1:0] lf;
        int pairs[$];
        lf = (seed == 0) ? 1 : seed;
        m_skips = 0;
        while (pairs.size() < K) begin
            if (lf == uq)
                m_skips++;
            else
                pairs.push_back(int'(lf));
            lf = {lf[W-2:0], 1'(($countones(lf & TAPS)) % 2)};
        end
        exp_id.delete();
        exp_dat.delete();
        for (int i = 0; i < N; i++) begin
            exp_id.push_back((i * STRIDE) % N);
            if (i < K)
                exp_dat.push_back(pairs[i]);
            else if (i == K)
                exp_dat.push_back(int'(uq));
            else
                exp_dat.push_back(pairs[2 * K - i]);
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (mon_on) begin
            bit busy_exp;
            bit done_exp;
            busy_exp = (cyc >= 1) && !(exp_id.size() == 0 && last_acc < cyc);
            done_exp = (cyc >= 1) && exp_id.size() == 0 && last_acc == cyc - 1;
            chk("busy", int'(gen_busy_r), int'(busy_exp));
            chk("done", int'(gen_done_r), int'(done_exp));
            if (cyc == 0)
                chk("idle_upt", int'(state_upt), 0);
            if (stall_prev) begin
                chk("stall_upt", int'(state_upt), 1);
                chk("stall_id", int'(state_id), stall_id);
                chk("stall_dat", int'(state_dat), stall_dat);
            end
            if (done_exp)
                chk("done_upt", int'(state_upt), 0);
            if (state_upt && state_rdy) begin
                if (exp_id.size() == 0) begin
                    chk("extra_write", 1, 0);
                end else begin
                    chk("wr_id", int'(state_id), exp_id.pop_front());
                    chk("wr_dat", int'(state_dat), exp_dat.pop_front());
                end
                last_acc = cyc;
            end
            stall_prev = state_upt && !state_rdy;
            stall_id   = int'(state_id);
            stall_dat  = int'(state_dat);
            if (done_exp) begin
                done_cyc = cyc;
                mon_on = 0;
            end
            cyc++;
        end
    end

    task automatic arm(input logic [W-1:0] seed, input logic [W-1:0] uq);
        build(seed, uq);
        cyc = 0;
        last_acc = -10;
        done_cyc = -1;
        stall_prev = 0;
        gen_seed = seed;
        gen_unique = uq;
        gen_start = 1'b1;
        mon_on = 1;
    endtask

    // One full generation; exp_done < 0 means any completion cycle is fine
    task automatic run(input logic [W-1:0] seed, input logic [W-1:0] uq,
                       input bit rnd, input bit poke, input int exp_done);
        int i;
        arm(seed, uq);
        if (!rnd)
            state_rdy = 1'b1;
        i = 0;
        while (mon_on && i < 400) begin
            @(posedge clk);
            #1;
            gen_start = poke && (i == 3);
            if (poke && i == 3) begin
                gen_seed = W'($urandom);
                gen_unique = W'($urandom);
            end
            state_rdy = rnd ? 1'($urandom % 2) : 1'b1;
            i++;
        end
        gen_start = 1'b0;
        if (mon_on) begin
            chk("timeout", 1, 0);
            mon_on = 0;
            @(posedge clk);
            #1;
        end
        chk("left_writes", exp_id.size(), 0);
        if (exp_done >= 0)
            chk("done_cycle", done_cyc, exp_done);
    endtask

    initial begin
        int lit_id[N];
        int lit_dat[N];
        int pin_pairs[K];
        lit_id  = '{0, 3, 6, 9, 12, 15, 1, 4, 7, 10, 13, 16, 2, 5, 8, 11, 14};
        lit_dat = '{'h01, 'h02, 'h04, 'h09, 'h12, 'h05, 'h0B, 'h16, 'h1F,
                    'h16, 'h0B, 'h05, 'h12, 'h09, 'h04, 'h02, 'h01};
        pin_pairs = '{'h01, 'h02, 'h09, 'h12, 'h05, 'h0B, 'h16, 'h0C};

        // Pin the model against hand-derived sequences
        build(5'h01, 5'h1F);
        for (int i = 0; i < N; i++) begin
            chk("model_id", exp_id[i], lit_id[i]);
            chk("model_dat", exp_dat[i], lit_dat[i]);
        end
        chk("model_skips0", m_skips, 0);
        build(5'h01, 5'h04);
        chk("model_skips1", m_skips, 1);
        for (int i = 0; i < K; i++)
            chk("model_pair", exp_dat[i], pin_pairs[i]);
        chk("model_uniq_slot", exp_id[K], 7);
        chk("model_uniq_dat", exp_dat[K], 'h04);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_upt", int'(state_upt), 0);
        chk("rst_busy", int'(gen_busy_r), 0);
        chk("rst_done", int'(gen_done_r), 0);
        @(posedge clk);
        #1;

        run(5'h01, 5'h1F, 0, 0, 18);
        run(5'h01, 5'h04, 0, 0, 19);
        run(5'h00, 5'h1F, 0, 0, 18);
        run(5'h01, 5'h1F, 1, 0, -1);
        run(5'h01, 5'h1F, 0, 1, 18);

        // Abort after the fifth write, then a clean full run
        arm(5'h01, 5'h1F);
        state_rdy = 1'b1;
        @(posedge clk);
        #1;
        gen_start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        mon_on = 0;
        chk("abort_writes", N - exp_id.size(), 5);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_upt", int'(state_upt), 0);
        chk("abort_busy", int'(gen_busy_r), 0);
        for (int i = 0; i < 20; i++) begin
            chk("abort_no_done", int'(gen_done_r), 0);
            chk("abort_quiet", int'(state_upt), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        run(5'h01, 5'h1F, 0, 0, 18);

        for (int r = 0; r < 40; r++)
            run(W'($urandom), W'($urandom), 1'($urandom % 2), 1'($urandom % 2), -1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/missing_duplicated_word_gen.md
Name: missing_duplicated_word_gen

Overview:
- Stimulus/table writer for the missing-duplicated-word finder.
- On a start command it fills an N-entry table of W-bit words through the finder's state-update interface.
- The table holds K=(N-1)/2 distinct pair values, each written exactly twice, plus one unique word written once.
- Pair values come from an LFSR; slot placement uses a fixed stride; second copies are replayed from an internal LIFO.

Parameters:
- W, 5, word width.
- N, 17, table entries; must be odd, ≥3.
- STRIDE, 3, slot step; 0<STRIDE<N, coprime with N.
- TAPS, 5'b10100, LFSR feedback mask (x^5+x^3+1); must be maximal-length for W. Constraint: 2^W-1 ≥ K+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- gen_start  in  1  start pulse; sampled only when idle.
- gen_seed  in  W  LFSR seed; 0 is replaced by 1.
- gen_unique  in  W  the single unpaired word.
- gen_busy_r  out  1  high from the cycle after start until done.
- gen_done_r  out  1  one-cycle pulse after the last write is accepted.
- state_upt  out  1  write valid.
- state_id  out  $clog2(N)  write slot.
- state_dat  out  W  write data.
- state_rdy  in  1  sink accepts the write when state_upt & state_rdy.

Behaviour:
- Reset: FSM to IDLE. gen_busy_r=0, gen_done_r=0, state_upt=0, LIFO empty, slot=0. state_id/state_dat are don't-care while state_upt=0.
- Reset mid-operation aborts immediately. No further writes; no done pulse.
- IDLE, gen_start=1: latch gen_unique, load LFSR=(gen_seed==0)?1:gen_seed, slot=0, pair count=0, go to FILL. gen_busy_r is high the next cycle.
- gen_start while busy is ignored.
- FILL:
  - If lfsr==unique_r, this is a skip cycle: state_upt=0, LFSR advances, no write. The skip costs exactly one cycle.
  - Otherwise state_upt=1, state_id=slot, state_dat=lfsr.
  - On accept: push lfsr to the LIFO, advance LFSR, slot=slot+STRIDE mod N, count++.
  - After the K-th accept, go to UNIQ.
- UNIQ: state_upt=1, dat=unique_r. On accept, advance slot and go to DRAIN.
- DRAIN:
  - state_upt=1, dat=LIFO top. On accept, pop and advance slot.
  - When the pop empties the LIFO, go to DONE.
- DONE: gen_done_r=1 for one cycle, gen_busy_r=0 in the same cycle, state_upt=0, then IDLE.
- A new start is accepted in the DONE cycle's successor (IDLE).
- Back-pressure: when state_upt=1 and state_rdy=0, state_id and state_dat hold stable; no state advances. Skip cycles do not wait for state_rdy.
- LFSR next value: {lfsr[W-2:0], ^(lfsr & TAPS)}.
- Slot next value: (slot+STRIDE ≥ N) ? slot+STRIDE-N : slot+STRIDE, computed at width $clog2(N)+1.
- The N writes visit every slot exactly once, because STRIDE is coprime with N.
- Latency with state_rdy tied to 1: first write the cycle after start; N write cycles plus one per skip; done pulse the cycle after the last write.
- LIFO: K entries of W bits, push/pop pointer. Never pushed when full or popped when empty by construction; an assertion checks both.
- Pair values are distinct and never equal unique_r.

Decomposition:
- Package mdw_pkg: w_t, id_t, K as localparam (N-1)/2, FSM state enum {IDLE, FILL, UNIQ, DRAIN, DONE}, function lfsr_next(w_t, w_t taps), function slot_next(id_t).
- Shared with missing_duplicated_word for id_t and w_t.
- One natural sub-module: mdw_lifo (parameter DEPTH=K, W; push, pop, top, empty, full).

Test Plan:
- W=5, N=17, seed=1, unique=0x1F, rdy=1 -> writes (slot:dat) 0:01, 3:02, 6:04, 9:09, 12:12, 15:05, 1:0B, 4:16, 7:1F, 10:16, 13:0B, 16:05, 2:12, 5:09, 8:04, 11:02, 14:01. done pulses at cycle 18 (start at cycle 0).
- seed=1, unique=0x04 -> one skip cycle. Pairs are 01,02,09,12,05,0B,16,0C; 04 is written once at slot 7. done pulses at cycle 19.
- seed=0 -> identical sequence to seed=1.
- state_rdy toggled 1/0 pseudo-randomly -> same write sequence as the first scenario; id/dat stable across stalls; no writes duplicated or dropped.
- rst asserted after the 5th write -> state_upt=0 and gen_busy_r=0 next cycle, no done pulse. A following start produces the full fresh sequence.
- Generator driving missing_duplicated_word, then cntrl_start after done -> finder reports cntrl_dat_r == gen_unique. Repeat for 50 random seed/unique pairs.
